// File: rtl/nios2os_pio_bidir_irq_if.sv
// Avalon-MM slave bundle for the bidirectional PIO: register bus plus CPU irq.
interface nios2os_pio_bidir_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios2os_pio_bidir_irq.sv
// WIDTH-bit bidirectional PIO with input synchroniser, edge capture and masked irq.
// Optional atomic outset/outclear registers at addresses 4/5 under `PIO_BIT_SET_CLEAR_EN.
module nios2os_pio_bidir_irq #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios2os_pio_bidir_irq_if.slave    bus,
  inout  wire  [WIDTH-1:0]          bidir_port
);

  logic [WIDTH-1:0]                   data_out;
  logic [WIDTH-1:0]                   dir;
  logic [WIDTH-1:0]                   mask;
  logic [WIDTH-1:0]                   edgecap;
  logic [WIDTH-1:0]                   prev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]                   sync_in;
  logic [WIDTH-1:0]                   rise;
  logic [WIDTH-1:0]                   fall;
  logic [WIDTH-1:0]                   detect;
  logic [WIDTH-1:0]                   clr;
  logic [WIDTH-1:0]                   wdata;
  logic                               wr_en;
  logic [31:0]                        rdata_q;
  logic                               irq_q;
  logic                               unused_writedata;

  assign wr_en            = bus.chipselect & ~bus.write_n;
  assign wdata            = bus.writedata[WIDTH-1:0];
  assign unused_writedata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // Pins are sampled even when driven by us, so reads reflect the real pad state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bidir_port};
      prev   <= sync_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev;
  assign fall    = ~sync_in & prev;

  always_comb begin
    case (EDGE_TYPE)
      1:       detect = fall;
      2:       detect = rise | fall;
      default: detect = rise;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= '0;
      mask     <= '0;
    end else if (wr_en) begin
      case (bus.address)
        3'd0: data_out <= wdata;
        3'd1: dir      <= wdata;
        3'd2: mask     <= wdata;
`ifdef PIO_BIT_SET_CLEAR_EN
        3'd4: data_out <= data_out | wdata;
        3'd5: data_out <= data_out & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  // A fresh edge outranks a simultaneous write-one-to-clear so no event is lost.
  assign clr = (wr_en && bus.address == 3'd3) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
      irq_q   <= 1'b0;
    end else begin
      edgecap <= (edgecap & ~clr) | detect;
      irq_q   <= |(edgecap & mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      case (bus.address)
        3'd0:    rdata_q <= 32'(sync_in);
        3'd1:    rdata_q <= 32'(dir);
        3'd2:    rdata_q <= 32'(mask);
        3'd3:    rdata_q <= 32'(edgecap);
        default: rdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: doc/nios2os_pio_bidir_irq.md
Name: nios2os_pio_bidir_irq

Overview:
- Parametrised, WIDTH-bit bidirectional PIO for the Nios II Qsys system.
- Generalises the single-pin touch-interrupt port to a bus with per-bit direction, input synchroniser, edge capture and a maskable interrupt.
- Avalon-MM slave: fixed read latency 1, no waitrequest; one level-high irq to the CPU.

Parameters:
- WIDTH, 8, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- RESET_OUT, 0, reset value of the data_out register (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register select (word address).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- readdata  out  32  registered read data; upper bits zero.
- irq  out  1  level interrupt, high while any masked capture bit is set.
- bidir_port  inout  WIDTH  pins; bit i driven by data_out[i] when dir[i]=1, else Z.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All registers async-cleared, otherwise posedge clk.
- Reset values: data_out=RESET_OUT, dir=0 (all inputs), mask=0, edgecap=0, sync chain=0, prev=0, readdata=0, irq=0.
- Input path: pins pass through a SYNC_STAGES flop chain giving sync_in. prev <= sync_in every cycle.
  - Reading a pin set as output returns the pin value after sync delay, not data_out.
- Edge detect on sync_in vs prev:
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - EDGE_TYPE selects rise, fall or rise|fall.
  - Detection applies to all bits regardless of dir.
- Register map (write = chipselect & ~write_n):
  - 0 data: R sync_in; W data_out.
  - 1 direction: R/W dir.
  - 2 irqmask: R/W mask.
  - 3 edgecapture: R edgecap; W1C (writing 1 clears the bit, 0 leaves it).
  - 4, 5: see Optional Feature; otherwise read 0, writes ignored.
  - 6, 7: read 0, writes ignored.
- Read latency: readdata updates every clk from address, regardless of chipselect. Value for address A is valid one cycle after A is presented.
- Edgecapture update per bit: next = (edgecap & ~clr) | detect.
  - A detect in the same cycle as a W1C on that bit leaves the bit set (detect wins).
- irq = |(edgecap & mask), registered. It asserts 1 cycle after edgecap/mask change and deasserts 1 cycle after clear.
  - Minimum pin-to-irq latency: SYNC_STAGES+2 clocks.
- Direction change: the output enable follows the dir register with no extra delay.
  - Switching output to input leaves data_out unchanged.
- Mid-operation reset: all state clears immediately, pins go Z, pending irq drops combinationally with the reset assert.

Optional Feature:
- Macro PIO_BIT_SET_CLEAR_EN.
- When defined:
  - address 4 = outset: W sets data_out bits written 1.
  - address 5 = outclear: W clears data_out bits written 1.
  - Both read 0. Atomic per-bit update with no read-modify-write.
- When undefined: addresses 4/5 behave as reserved (read 0, ignore writes).

Test Plan:
- Reset then read addr 0..3 with pins pulled 0 -> readdata 0; bidir_port all Z; irq 0.
- WIDTH=8: write dir=0x0F, data=0xA5 -> pins[3:0]=0x5, pins[7:4]=Z; read addr0 after SYNC_STAGES+1 cycles -> low nibble 0x5.
- EDGE_TYPE=0, mask=0x80, drive pin7 0->1 -> edgecap=0x80, irq=1 at SYNC_STAGES+2 clocks; write addr3=0x80 -> edgecap 0, irq 0 next cycle.
- W1C of bit7 in the same cycle as a new rising edge on pin7 -> edgecap[7] stays 1, irq stays 1.
- Edge on pin2 with mask=0 -> edgecap=0x04, irq 0; then write mask=0x04 -> irq 1 one cycle later.
- With PIO_BIT_SET_CLEAR_EN: data_out=0x00, write addr4=0x11 then addr5=0x01 -> data_out 0x10. Without the macro the same writes leave data_out 0x00.
